// File: rtl/dds_pkg.sv
// Shared definitions for the quarter-wave DDS sequencer: quadrant
// encodings, ROM direction / output polarity constants, default widths
// and small helpers that decode a quadrant into direction and polarity.
package dds_pkg;

  localparam int DEF_ACC_W  = 24;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 12;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  localparam logic FORWARD  = 1'b0;
  localparam logic BACKWARD = 1'b1;
  localparam logic POL_POS  = 1'b0;
  localparam logic POL_NEG  = 1'b1;

  // Odd quadrants read the quarter table mirrored (backward).
  function automatic logic quad_dir(input quadrant_t q);
    return q[0] ? BACKWARD : FORWARD;
  endfunction

  // The second half of the period is the negated first half.
  function automatic logic quad_pol(input quadrant_t q);
    return q[1] ? POL_NEG : POL_POS;
  endfunction

endpackage

// File: rtl/dds_ftw_sync.sv
// Tuning-word holding register. A new word is captured into a pending
// slot and only becomes the active step when the sequencer reports a
// safe point (carry-out while running, idle cycle, or phase load).
module dds_ftw_sync #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] ftw_in,
  input  logic         ftw_valid,
  input  logic         commit_ok,
  output logic         ftw_ready,
  output logic [W-1:0] ftw_act
);

  logic         pending;
  logic [W-1:0] ftw_pend;

  // Handshake: a word transfers on a cycle where ftw_valid and ftw_ready
  // are both high. ftw_ready is low while a word is pending; ftw_valid in
  // those cycles is ignored and nothing is captured.
  assign ftw_ready = ~pending;

  // Capture an offered word, then move it to the active slot at a safe point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      ftw_pend <= '0;
      ftw_act  <= '0;
    end else if (ftw_valid && !pending) begin
      pending  <= 1'b1;
      ftw_pend <= ftw_in;
    end else if (pending && commit_ok) begin
      pending  <= 1'b0;
      ftw_act  <= ftw_pend;
    end
  end

endmodule

// File: rtl/dds_quarter_seq.sv
// Quarter-wave sine DDS sequencer: phase accumulator, quadrant decode,
// quarter-table addressing and output sign application. The ROM is
// external and answers one cycle after rom_addr.
// Optional build macro DDS_PHASE_DITHER_EN adds LFSR phase dither to the
// address/quadrant derivation only (stored accumulator is unaffected).
module dds_quarter_seq
  import dds_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              src_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_valid,
  output logic              ftw_ready,
  input  logic              phase_set,
  input  logic [ACC_W-1:0]  phase_off,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [1:0]        quadrant,
  output logic [DATA_W:0]   sample_out,
  output logic              sample_valid,
  output logic              wrap
);

  // Quadrant bits plus table index taken from the top of the phase.
  localparam int PH_W  = ADDR_W + 2;
  localparam int LOW_W = ACC_W - PH_W;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  ftw_act;
  logic [ACC_W:0]    sum;
  logic              carry;
  logic              commit_ok;
  logic [PH_W-1:0]   phase_hi;
  quadrant_t         q_cur;
  quadrant_t         q_d1;
  quadrant_t         q_d2;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] addr_next;
  logic              v_d1;
  logic              v_d2;

  assign sum   = {1'b0, acc} + {1'b0, ftw_act};
  assign carry = sum[ACC_W];

  // A pending word may only take effect at a carry, an idle cycle or a
  // phase load, so the running waveform never changes step mid-period.
  assign commit_ok = phase_set | ~en | carry;

  dds_ftw_sync #(
    .W (ACC_W)
  ) u_ftw_sync (
    .clk       (src_clk),
    .rst_n     (rst_n),
    .ftw_in    (ftw_in),
    .ftw_valid (ftw_valid),
    .commit_ok (commit_ok),
    .ftw_ready (ftw_ready),
    .ftw_act   (ftw_act)
  );

`ifdef DDS_PHASE_DITHER_EN
  localparam int DITH_W = (LOW_W > 16) ? 16 : LOW_W;

  logic [15:0] lfsr;

  // Galois LFSR (taps 16,14,13,11), stepped once per accumulator advance.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (en) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign phase_hi = PH_W'((acc + ACC_W'(lfsr[DITH_W-1:0])) >> LOW_W);
`else
  assign phase_hi = acc[ACC_W-1 -: PH_W];
`endif

  assign q_cur     = quadrant_t'(phase_hi[PH_W-1 -: 2]);
  assign idx       = phase_hi[ADDR_W-1:0];
  assign addr_next = (quad_dir(q_cur) == BACKWARD) ? ~idx : idx;

  // Accumulator: phase load wins over stepping; wrap flags the carry-out.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (phase_set) begin
      acc  <= phase_off;
      wrap <= 1'b0;
    end else if (en) begin
      acc  <= sum[ACC_W-1:0];
      wrap <= carry;
    end else begin
      wrap <= 1'b0;
    end
  end

  // Three-stage sample pipeline: address, ROM wait, signed output.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr     <= '0;
      q_d1         <= Q0;
      v_d1         <= 1'b0;
      q_d2         <= Q0;
      v_d2         <= 1'b0;
      sample_out   <= '0;
      quadrant     <= 2'd0;
      sample_valid <= 1'b0;
    end else begin
      rom_addr     <= addr_next;
      q_d1         <= q_cur;
      v_d1         <= en | phase_set;
      q_d2         <= q_d1;
      v_d2         <= v_d1;
      sample_out   <= (quad_pol(q_d2) == POL_NEG) ? -{1'b0, rom_data}
                                                  :  {1'b0, rom_data};
      quadrant     <= q_d2;
      sample_valid <= v_d2;
    end
  end

endmodule

// File: tb/tb_dds_quarter_seq.sv
// Bench for dds_quarter_seq: synchronous model ROM (data = addr<<4),
// arithmetic reference of the phase-to-sample mapping, expected-sample
// queue with arrival cycle, and a monitor that checks outputs each cycle.
module tb_dds_quarter_seq;

  localparam int ACC_W  = 24;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 12;
  localparam int EW     = 32 + 2 + DATA_W + 1;
  localparam longint unsigned MOD = 64'd1 << ACC_W;

  logic              src_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [ACC_W-1:0]  ftw_in = '0;
  logic              ftw_valid = 1'b0;
  logic              ftw_ready;
  logic              phase_set = 1'b0;
  logic [ACC_W-1:0]  phase_off = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic [1:0]        quadrant;
  logic [DATA_W:0]   sample_out;
  logic              sample_valid;
  logic              wrap;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dith_diff = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] head;

  // Reference model state
  longint unsigned m_acc, m_ftw, m_pw;
  bit              m_pend;
  int              exp_addr;
  bit              exp_wrap;
  bit              exp_ready;

  dds_quarter_seq dut (
    .src_clk      (src_clk),
    .rst_n        (rst_n),
    .en           (en),
    .ftw_in       (ftw_in),
    .ftw_valid    (ftw_valid),
    .ftw_ready    (ftw_ready),
    .phase_set    (phase_set),
    .phase_off    (phase_off),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .quadrant     (quadrant),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  // Clock
  always #5 src_clk = ~src_clk;

  // Model quarter-wave ROM, one cycle read latency
  always @(posedge src_clk) rom_data <= {rom_addr, 4'b0000};

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Reference mapping from the phase value, plain arithmetic
  function automatic int ref_quad(input longint unsigned a);
    return int'(a / (MOD / 4));
  endfunction

  function automatic int ref_addr(input longint unsigned a);
    int idx;
    idx = int'((a / (MOD / (4 * (2 ** ADDR_W)))) % (2 ** ADDR_W));
    return (ref_quad(a) % 2 == 1) ? (2 ** ADDR_W) - 1 - idx : idx;
  endfunction

  function automatic int ref_sample(input longint unsigned a);
    int mag;
    mag = ref_addr(a) * 16;
    return (ref_quad(a) >= 2) ? -mag : mag;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_ftw = 0; m_pw = 0; m_pend = 0;
    exp_addr = 0; exp_wrap = 0; exp_ready = 1;
  endtask

  // One clock of the reference, using the inputs about to be sampled
  task automatic model_step();
    longint unsigned s;
    bit carry, commit;
    exp_addr = ref_addr(m_acc);
    if (en || phase_set)
      exp_q.push_back({32'(cyc + 3), 2'(ref_quad(m_acc)), 13'(ref_sample(m_acc))});
    s = m_acc + m_ftw;
    carry = (s >= MOD);
    commit = m_pend && (phase_set || !en || carry);
    if (phase_set) begin
      m_acc = longint'(phase_off); exp_wrap = 0;
    end else if (en) begin
      m_acc = s % MOD; exp_wrap = carry;
    end else begin
      exp_wrap = 0;
    end
    if (ftw_valid && !m_pend) begin
      m_pend = 1; m_pw = longint'(ftw_in);
    end else if (commit) begin
      m_pend = 0; m_ftw = m_pw;
    end
    exp_ready = !m_pend;
  endtask

  // Driver: apply one cycle of inputs on the falling edge
  task automatic tick(input logic e, input logic ps, input logic [ACC_W-1:0] po,
                      input logic fv, input logic [ACC_W-1:0] fw);
    @(negedge src_clk);
    en = e; phase_set = ps; phase_off = po; ftw_valid = fv; ftw_in = fw;
    model_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_quadrant"}, quadrant, 0);
    check({tag, "_sample_out"}, sample_out, 0);
    check({tag, "_sample_valid"}, sample_valid, 0);
    check({tag, "_wrap"}, wrap, 0);
    check({tag, "_ftw_ready"}, ftw_ready, 1);
  endtask

  // Monitor: checks registered outputs 2 time units after each rising edge
  initial begin
    forever begin
      @(posedge src_clk);
      cyc++;
      #2;
      if (rst_n) begin
`ifdef DDS_PHASE_DITHER_EN
        if (int'(rom_addr) != exp_addr) dith_diff++;
        check("rom_addr_within_1", ((int'(rom_addr) - exp_addr) <= 1 &&
                                    (exp_addr - int'(rom_addr)) <= 1), 1);
`else
        check("rom_addr", rom_addr, exp_addr);
`endif
        check("wrap", wrap, exp_wrap);
        check("ftw_ready", ftw_ready, exp_ready);
        if (sample_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sample_unexpected: actual=valid required=none cycle=%0d", cyc);
          end else begin
            head = exp_q.pop_front();
            check("sample_latency", cyc, int'(head[EW-1 -: 32]));
`ifdef DDS_PHASE_DITHER_EN
            check("sample_within_16",
                  (($signed(sample_out) - $signed(head[DATA_W:0])) <= 16 &&
                   ($signed(head[DATA_W:0]) - $signed(sample_out)) <= 16), 1);
`else
            check("quadrant", quadrant, head[DATA_W+2 -: 2]);
            check("sample_out", $signed(sample_out), $signed(head[DATA_W:0]));
`endif
          end
        end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
          checks++; errors++;
          $display("FAIL sample_missing: actual=none required=due@%0d cycle=%0d",
                   int'(exp_q[0][EW-1 -: 32]), cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus sequence
  initial begin
    model_reset();
    repeat (3) @(negedge src_clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Load 2^14 while idle, commit on the next idle cycle, then run 1100 steps
    tick(1'b0, 1'b0, '0, 1'b1, 24'd16384);
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    run(1100);

    // Phase load to the start of quadrant 2
    tick(1'b1, 1'b1, 24'h800000, 1'b0, '0);
    run(300);

    // Mid-period retune to 2^15, second offer while pending must be ignored
    run(100);
    tick(1'b1, 1'b0, '0, 1'b1, 24'd32768);
    run(50);
    tick(1'b1, 1'b0, '0, 1'b1, 24'h003039);
    run(1100);

    // Pending word committed by an idle cycle
    tick(1'b1, 1'b0, '0, 1'b1, 24'd16384);
    run(5);
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    run(20);

    // Randomised mix of stepping, idling, phase loads and retunes
    for (int i = 0; i < 1500; i++) begin
      tick(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 49) == 0),
           ACC_W'($urandom), 1'($urandom_range(0, 19) == 0), ACC_W'($urandom));
    end

    // Into quadrant 3, then asynchronous reset between edges
    tick(1'b0, 1'b0, '0, 1'b1, 24'd16384);
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    tick(1'b1, 1'b1, 24'hC00000, 1'b0, '0);
    run(100);
    @(negedge src_clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    exp_q.delete();
    model_reset();
    en = 1'b0; phase_set = 1'b0; ftw_valid = 1'b0;
    @(negedge src_clk);
    rst_n = 1'b1;

    // After reset the tuning word is zero: output stays at phase 0
    run(20);

    // Drain the pipeline
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge src_clk);
    check("queue_drained", exp_q.size(), 0);
`ifdef DDS_PHASE_DITHER_EN
    check("dither_changes_addr", (dith_diff > 0), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
